// File: rtl/local_program_runner.sv
// local_program_runner: loads a small program and an expected-output table,
// runs the program one instruction per cycle against a local register file,
// then compares the produced outputs with the table and reports pass/fail.
// load_valid / exp_valid are single-cycle write strobes with no ready: a
// strobe is taken on any clock edge where reset=1 and the block is in IDLE
// or DONE, and is silently dropped otherwise (busy or in reset).
// dbg_state encoding: 0 IDLE, 1 RUN, 2 CHECK, 3 DONE.
module local_program_runner #(
    parameter int WIDTH    = 12,
    parameter int NLOCAL   = 8,
    parameter int NPROG    = 16,
    parameter int NOUT     = 4,
    parameter int MAXSTEPS = 64,
    localparam int A  = (NLOCAL > 1) ? $clog2(NLOCAL) : 1,
    localparam int P  = (NPROG > 1) ? $clog2(NPROG) : 1,
    localparam int O  = $clog2(NOUT + 1),
    localparam int S  = $clog2(MAXSTEPS + 1),
    localparam int IW = 3 + 2 * A + WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [P-1:0]     load_addr,
    input  logic [IW-1:0]    load_instr,
    input  logic             exp_valid,
    input  logic [O-1:0]     exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [O-1:0]     exp_len,
    input  logic             start,
    output logic             busy,
    output logic             finished,
    output logic             success,
    output logic [O-1:0]     out_count,
    output logic [S-1:0]     steps,
    output logic [1:0]       dbg_state
);

    localparam int OI = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int PW = P + 1;
    localparam logic [O-1:0]     NOUT_C  = O'(NOUT);
    localparam logic [PW-1:0]    NPROG_C = PW'(NPROG);
    localparam logic [S-1:0]     MAXS_C  = S'(MAXSTEPS);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_OUT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_JNZ  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_INV  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]    prog     [NPROG];
    logic [WIDTH-1:0] expected [NOUT];
    logic [WIDTH-1:0] outmem   [NOUT];
    logic [WIDTH-1:0] locals   [NLOCAL];

    logic [P-1:0]     ip;
    logic [O-1:0]     exp_len_q;
    logic [O-1:0]     chk_idx;
    logic             timeout;

    logic [IW-1:0]    instr;
    logic [2:0]       op;
    logic [A-1:0]     dst, src;
    logic [WIDTH-1:0] imm, src_val, dst_val;
    logic [PW-1:0]    ip_inc;
    logic [S-1:0]     steps_inc;
    logic             jump, overflow, halt_now, timeout_now;
    logic             chk_end, chk_bad;
    logic             can_write;

    // Decode the current instruction and the run/check termination conditions.
    always_comb begin
        instr       = prog[ip];
        op          = instr[IW-1 -: 3];
        dst         = instr[WIDTH+2*A-1 -: A];
        src         = instr[WIDTH+A-1 -: A];
        imm         = instr[WIDTH-1:0];
        src_val     = locals[src];
        dst_val     = locals[dst];
        ip_inc      = {1'b0, ip} + PW'(1);
        steps_inc   = steps + S'(1);
        jump        = (op == OP_JNZ) && (src_val != '0);
        overflow    = (op == OP_OUT) && (out_count == NOUT_C);
        // Falling off the end of program memory behaves like HALT.
        halt_now    = (op == OP_HALT) || (!jump && (ip_inc == NPROG_C));
        timeout_now = !halt_now && (steps_inc == MAXS_C);
        chk_end     = (chk_idx == out_count);
        chk_bad     = !chk_end &&
                      (outmem[chk_idx[OI-1:0]] != expected[chk_idx[OI-1:0]]);
        can_write   = reset && ((state == S_IDLE) || (state == S_DONE));
    end

    // State register; reset returns to IDLE even mid-run.
    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_next = S_RUN;
            S_RUN: begin
                if (overflow)                      state_next = S_DONE;
                else if (halt_now || timeout_now)  state_next = S_CHECK;
            end
            S_CHECK: if (chk_end || chk_bad) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Program, expected table and output channel; these survive reset.
    always_ff @(posedge clock) begin
        if (can_write && load_valid) prog[load_addr] <= load_instr;
        if (can_write && exp_valid && (exp_addr < NOUT_C))
            expected[exp_addr[OI-1:0]] <= exp_data;
        if (reset && (state == S_RUN) && (op == OP_OUT) && !overflow)
            outmem[out_count[OI-1:0]] <= src_val;
    end

    // Execution datapath: register file, counters, and the pass/fail verdict.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NLOCAL; i++) locals[i] <= '0;
            ip        <= '0;
            steps     <= '0;
            out_count <= '0;
            success   <= 1'b0;
            timeout   <= 1'b0;
            chk_idx   <= '0;
            exp_len_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int i = 0; i < NLOCAL; i++) locals[i] <= '0;
                        ip        <= '0;
                        steps     <= '0;
                        out_count <= '0;
                        success   <= 1'b0;
                        timeout   <= 1'b0;
                        chk_idx   <= '0;
                        exp_len_q <= exp_len;
                    end
                end
                S_RUN: begin
                    steps   <= steps_inc;
                    ip      <= jump ? imm[P-1:0] : ip_inc[P-1:0];
                    timeout <= timeout_now;
                    case (op)
                        OP_MOVI: locals[dst] <= imm;
                        OP_NOT:  locals[dst] <= (src_val == '0) ? ONE_W : '0;
                        OP_OUT:  if (!overflow) out_count <= out_count + O'(1);
                        OP_ADD:  locals[dst] <= dst_val + src_val;
                        OP_INV:  locals[dst] <= ~src_val;
                        default: ;
                    endcase
                end
                S_CHECK: begin
                    if (chk_end)
                        success <= (out_count == exp_len_q) && !timeout;
                    else if (!chk_bad)
                        chk_idx <= chk_idx + O'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == S_RUN) || (state == S_CHECK);
    assign finished  = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_local_program_runner.sv
// Bench for local_program_runner: an instruction-level interpreter predicts
// the per-cycle busy/finished/out_count/steps/success trace of every run,
// and a compare process checks the DUT against that trace each cycle.
module tb_local_program_runner;

    localparam int WIDTH = 12, NLOCAL = 8, NPROG = 16, NOUT = 4, MAXSTEPS = 64;
    localparam int A = 3, P = 4, O = 3, S = 7, IW = 3 + 2 * A + WIDTH;
    localparam int EXTRA = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             load_valid;
    logic [P-1:0]     load_addr;
    logic [IW-1:0]    load_instr;
    logic             exp_valid;
    logic [O-1:0]     exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic [O-1:0]     exp_len;
    logic             start;
    logic             busy, finished, success;
    logic [O-1:0]     out_count;
    logic [S-1:0]     steps;
    logic [1:0]       dbg_state;

    local_program_runner #(
        .WIDTH(WIDTH), .NLOCAL(NLOCAL), .NPROG(NPROG), .NOUT(NOUT), .MAXSTEPS(MAXSTEPS)
    ) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_instr(load_instr),
        .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_len(exp_len), .start(start),
        .busy(busy), .finished(finished), .success(success),
        .out_count(out_count), .steps(steps), .dbg_state(dbg_state)
    );

    // Clock and edge counter
    always #5 clock = ~clock;
    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one expected record per clock edge after start
    typedef struct packed {
        logic         busy;
        logic         fin;
        logic [O-1:0] oc;
        logic [S-1:0] st;
        logic         sv;
        logic         succ;
    } rec_t;
    rec_t exp_q[$];

    function automatic rec_t mk_rec(input bit b, input bit f, input int oc, input int st,
                                    input bit sv, input bit sc);
        rec_t r;
        r.busy = b; r.fin = f; r.oc = oc[O-1:0]; r.st = st[S-1:0]; r.sv = sv; r.succ = sc;
        return r;
    endfunction

    always @(negedge clock) begin
        rec_t r;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("busy", busy, r.busy);
            check("finished", finished, r.fin);
            check("out_count", out_count, r.oc);
            check("steps", steps, r.st);
            if (r.sv) check("success", success, r.succ);
        end
    end

    // Behavioural model state
    logic [IW-1:0] prog_m [NPROG];
    int            exp_m  [NOUT];
    int            exp_len_m;
    int            m_outs [NOUT];
    int            m_oc;

    function automatic logic [IW-1:0] mk(input int op, input int d, input int s, input int imm);
        logic [IW-1:0] w;
        w = {op[2:0], d[A-1:0], s[A-1:0], imm[WIDTH-1:0]};
        return w;
    endfunction

    // Interpret the loaded program; optionally queue the cycle trace.
    task automatic model_build(input bit push);
        int regs [NLOCAL];
        int ip, nip, st, oc, op, d, s, imm, mis, clen;
        int mask;
        bit tmo, ovf, fin, sc;
        logic [IW-1:0] w;
        mask = (1 << WIDTH) - 1;
        for (int i = 0; i < NLOCAL; i++) regs[i] = 0;
        ip = 0; st = 0; oc = 0; tmo = 0; ovf = 0; fin = 0; mis = -1;
        if (push) exp_q.push_back(mk_rec(1, 0, 0, 0, 0, 0));
        while (!fin) begin
            w   = prog_m[ip];
            op  = int'(w[IW-1 -: 3]);
            d   = int'(w[WIDTH+2*A-1 -: A]);
            s   = int'(w[WIDTH+A-1 -: A]);
            imm = int'(w[WIDTH-1:0]);
            nip = ip + 1;
            st++;
            case (op)
                1: regs[d] = imm;
                2: regs[d] = (regs[s] == 0) ? 1 : 0;
                3: if (oc == NOUT) ovf = 1; else begin m_outs[oc] = regs[s]; oc++; end
                4: regs[d] = (regs[d] + regs[s]) & mask;
                5: if (regs[s] != 0) nip = imm % NPROG;
                7: regs[d] = (~regs[s]) & mask;
                default: ;
            endcase
            if (ovf) fin = 1;
            else if (op == 6 || nip >= NPROG) fin = 1;
            else if (st == MAXSTEPS) begin fin = 1; tmo = 1; end
            ip = nip;
            if (push) exp_q.push_back(mk_rec(!ovf, ovf, oc, st, ovf, 0));
        end
        m_oc = oc;
        sc = 0;
        if (!ovf) begin
            for (int i = 0; i < oc; i++)
                if (mis < 0 && m_outs[i] != exp_m[i]) mis = i;
            clen = (mis >= 0) ? mis + 1 : oc + 1;
            sc = (mis < 0) && (oc == exp_len_m) && !tmo;
            if (push) begin
                for (int i = 0; i < clen - 1; i++) exp_q.push_back(mk_rec(1, 0, oc, st, 0, 0));
                exp_q.push_back(mk_rec(0, 1, oc, st, 1, sc));
            end
        end
        if (push)
            for (int i = 0; i < EXTRA; i++) exp_q.push_back(mk_rec(0, 1, oc, st, 1, sc));
    endtask

    // Driver tasks
    task automatic push_prog();
        for (int a = 0; a < NPROG; a++) begin
            @(negedge clock); #1;
            load_valid = 1'b1; load_addr = a[P-1:0]; load_instr = prog_m[a];
        end
        @(negedge clock); #1;
        load_valid = 1'b0;
    endtask

    task automatic push_exp();
        for (int a = 0; a < NOUT; a++) begin
            @(negedge clock); #1;
            exp_valid = 1'b1; exp_addr = a[O-1:0]; exp_data = exp_m[a][WIDTH-1:0];
        end
        @(negedge clock); #1;
        exp_valid = 1'b0;
    endtask

    task automatic fill_prog(input int op);
        for (int a = 0; a < NPROG; a++) prog_m[a] = mk(op, 0, 0, 0);
    endtask

    int start_cnt;

    task automatic begin_run();
        @(negedge clock); #1;
        start = 1'b1; exp_len = exp_len_m[O-1:0];
        model_build(1);
        @(negedge clock); #1;
        start = 1'b0;
        start_cnt = cyc_cnt;
    endtask

    task automatic finish_run(output int cyc);
        int n;
        bit seen;
        n = 0; seen = 0; cyc = -1;
        while ((exp_q.size() > 0 || !seen) && n < 600) begin
            @(negedge clock); #1;
            n++;
            if (!seen && finished) begin seen = 1; cyc = cyc_cnt - start_cnt; end
        end
        if (n >= 600) begin
            check("run_bound", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic final_checks(input string tag, input int cyc, input int ecyc,
                                input int esucc, input int eoc, input int est);
        if (ecyc >= 0) check({tag, "_cycles"}, cyc, ecyc);
        check({tag, "_finished"}, finished, 1);
        check({tag, "_success"}, success, esucc);
        check({tag, "_out_count"}, out_count, eoc);
        check({tag, "_steps"}, steps, est);
    endtask

    task automatic load_t1();
        fill_prog(6);
        prog_m[0] = mk(1, 0, 0, 3);
        prog_m[1] = mk(2, 1, 0, 0);
        prog_m[2] = mk(2, 2, 1, 0);
        prog_m[3] = mk(3, 0, 0, 0);
        prog_m[4] = mk(3, 0, 1, 0);
        prog_m[5] = mk(3, 0, 2, 0);
        push_prog();
    endtask

    int op_tab [12] = '{0, 1, 1, 1, 2, 3, 3, 4, 5, 7, 2, 6};

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; exp_valid = 1'b0;
        load_addr = '0; load_instr = '0; exp_addr = '0; exp_data = '0; exp_len = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_success", success, 0);
        check("rst_out_count", out_count, 0);
        check("rst_steps", steps, 0);
        check("rst_dbg_state", dbg_state, 0);
        #1 reset = 1'b1;

        // Reference program, matching table; writes and start while busy are dropped
        load_t1();
        exp_m = '{3, 0, 1, 0}; exp_len_m = 3; push_exp();
        begin_run();
        start = 1'b1; exp_valid = 1'b1; exp_addr = '0; exp_data = 12'd999;
        load_valid = 1'b1; load_addr = 4'd6; load_instr = mk(1, 0, 0, 5);
        @(negedge clock); #1;
        start = 1'b0; exp_valid = 1'b0; load_valid = 1'b0;
        finish_run(cyc);
        final_checks("t1", cyc, 11, 1, 3, 7);

        // Same program, mismatch at entry 1
        exp_m = '{3, 1, 1, 0}; exp_len_m = 3; push_exp();
        begin_run(); finish_run(cyc);
        final_checks("t2", cyc, 9, 0, 3, 7);

        // Infinite loop hits the step limit
        fill_prog(6);
        prog_m[0] = mk(1, 0, 0, 1);
        prog_m[1] = mk(5, 0, 0, 1);
        push_prog();
        exp_len_m = 0;
        begin_run(); finish_run(cyc);
        final_checks("t3", cyc, 65, 0, 0, 64);

        // Five OUTs overflow a four-deep channel
        fill_prog(6);
        for (int a = 0; a < 5; a++) prog_m[a] = mk(3, 0, 0, 0);
        push_prog();
        exp_m = '{0, 0, 0, 0}; exp_len_m = 4; push_exp();
        begin_run(); finish_run(cyc);
        final_checks("t4", cyc, 5, 0, 4, 5);

        // Modular ADD: 4095 + 2 wraps to 1
        fill_prog(6);
        prog_m[0] = mk(1, 0, 0, 4095);
        prog_m[1] = mk(1, 1, 0, 2);
        prog_m[2] = mk(4, 0, 1, 0);
        prog_m[3] = mk(3, 0, 0, 0);
        push_prog();
        exp_m = '{1, 0, 0, 0}; exp_len_m = 1; push_exp();
        begin_run(); finish_run(cyc);
        final_checks("t5", cyc, 7, 1, 1, 5);

        // All NOPs: run off the end of program memory, empty check
        fill_prog(0);
        push_prog();
        exp_len_m = 0;
        begin_run(); finish_run(cyc);
        final_checks("t6", cyc, 17, 1, 0, 16);

        // Reset at step 3, stimulus ignored in reset, rerun without reload
        load_t1();
        exp_m = '{3, 0, 1, 0}; exp_len_m = 3; push_exp();
        begin_run();
        repeat (3) @(negedge clock);
        #1;
        check("t7_step3", steps, 3);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock); #1;
        check("t7_busy", busy, 0);
        check("t7_finished", finished, 0);
        check("t7_success", success, 0);
        check("t7_out_count", out_count, 0);
        check("t7_steps", steps, 0);
        start = 1'b1; load_valid = 1'b1; load_addr = '0; load_instr = mk(6, 0, 0, 0);
        exp_valid = 1'b1; exp_addr = '0; exp_data = 12'd77;
        @(negedge clock); #1;
        check("t7_rst_start_ignored", busy, 0);
        start = 1'b0; load_valid = 1'b0; exp_valid = 1'b0;
        reset = 1'b1;
        begin_run(); finish_run(cyc);
        final_checks("t7", cyc, 11, 1, 3, 7);

        // Randomized programs and tables
        for (int t = 0; t < 24; t++) begin
            for (int a = 0; a < NPROG; a++) begin
                int op;
                op = op_tab[$urandom_range(0, 11)];
                prog_m[a] = mk(op, $urandom_range(0, 7), $urandom_range(0, 7),
                               (op == 5) ? $urandom_range(0, 15) : $urandom_range(0, 4095));
            end
            push_prog();
            model_build(0);
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < NOUT; i++)
                    exp_m[i] = (i < m_oc) ? m_outs[i] : $urandom_range(0, 4095);
                exp_len_m = m_oc;
                if (m_oc > 0 && $urandom_range(0, 3) == 0)
                    exp_m[$urandom_range(0, m_oc - 1)] ^= 1;
            end else begin
                for (int i = 0; i < NOUT; i++) exp_m[i] = $urandom_range(0, 3);
                exp_len_m = $urandom_range(0, NOUT);
            end
            push_exp();
            begin_run(); finish_run(cyc);
            check("rnd_finished", finished, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
